// File: rtl/change_monitor_pkg.sv
// change_mon_pkg: shared mode encodings and width helper for change_monitor
package change_mon_pkg;
    localparam logic [1:0] MODE_ANY  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;
    function automatic int fch_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/change_monitor_if.sv
// change_monitor_if: monitored lines, controls and fault/status readout
interface change_monitor_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
    import change_mon_pkg::*;
    localparam int FW = fch_w(WIDTH);
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] e;
    logic [1:0]       mode;
    logic             clr;
    logic [WIDTH-1:0] err;
    logic             err_any;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [FW-1:0]    first_ch;
    logic             first_vld;
    modport master(output i, e, mode, clr,
                   input err, err_any, armed, cnt, first_ch, first_vld);
    modport slave(input i, e, mode, clr,
                  output err, err_any, armed, cnt, first_ch, first_vld);
endinterface

// File: rtl/change_monitor_edge_cell.sv
// chg_edge_cell: one channel - previous-value flop, edge select, gating, sticky error
module chg_edge_cell
    import change_mon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i,
    input  logic       e,
    input  logic       armed,
    input  logic       clr,
    input  logic [1:0] mode,
    output logic       det,
    output logic       err
);
    logic prev;
    logic edg;
    always_comb
        edg = (mode == MODE_ANY)  ? (i ^ prev) :
              (mode == MODE_RISE) ? (i & ~prev) :
              (mode == MODE_FALL) ? (~i & prev) : 1'b0;
    assign det = armed & e & edg;
    always_ff @(posedge clk)
        if (rst) begin
            prev <= 1'b0;
            err  <= 1'b0;
        end else begin
            prev <= i;
            err  <= (err & ~clr) | det;
        end
endmodule

// File: rtl/change_monitor.sv
// change_monitor: multi-channel transition monitor with arming, sticky errors,
// saturating event count and first-fault capture
module change_monitor
    import change_mon_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 8,
    parameter int ARM_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    change_monitor_if.slave bus
);
    localparam int FW = fch_w(WIDTH);
    localparam int AW = $clog2(ARM_CYCLES + 1);
    logic [AW-1:0]    arm_cnt;
    logic             armed;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] err;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_base;
    logic [FW-1:0]    first_ch;
    logic [FW-1:0]    low;
    logic             first_vld;
    assign armed = (arm_cnt == AW'(ARM_CYCLES));
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        chg_edge_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .i    (bus.i[g]),
            .e    (bus.e[g]),
            .armed(armed),
            .clr  (bus.clr),
            .mode (bus.mode),
            .det  (det[g]),
            .err  (err[g])
        );
    end
    // scan downward so the lowest detecting channel wins
    always_comb begin
        low = '0;
        for (int k = WIDTH - 1; k >= 0; k--)
            if (det[k]) low = FW'(k);
    end
    assign cnt_base = bus.clr ? '0 : cnt;
    always_ff @(posedge clk)
        if (rst) begin
            arm_cnt   <= '0;
            cnt       <= '0;
            first_ch  <= '0;
            first_vld <= 1'b0;
        end else begin
            if (!armed) arm_cnt <= arm_cnt + 1'b1;
            cnt <= (|det && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
            if (|det && (!first_vld || bus.clr)) begin
                first_ch  <= low;
                first_vld <= 1'b1;
            end else if (bus.clr) begin
                first_ch  <= '0;
                first_vld <= 1'b0;
            end
        end
    assign bus.err       = err;
    assign bus.err_any   = |err;
    assign bus.armed     = armed;
    assign bus.cnt       = cnt;
    assign bus.first_ch  = first_ch;
    assign bus.first_vld = first_vld;
endmodule

// File: tb/tb_change_monitor.sv
// tb_change_monitor: directed checks of arming, modes, masking, clear race,
// saturation and mid-run reset
module tb_change_monitor;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    change_monitor_if #(.WIDTH(8), .CNT_W(4)) bus ();
    change_monitor #(.WIDTH(8), .CNT_W(4), .ARM_CYCLES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        rst = 1'b1;
        bus.i = 8'hFF;
        bus.e = 8'hFF;
        bus.mode = 2'b00;
        bus.clr = 1'b0;
        tick();
        chk("rst_err", 32'(bus.err), 32'h00);
        chk("rst_cnt", 32'(bus.cnt), 32'h0);
        chk("rst_armed", 32'(bus.armed), 32'h0);
        chk("rst_vld", 32'(bus.first_vld), 32'h0);
        rst = 1'b0;
        tick();
        chk("arm1_armed", 32'(bus.armed), 32'h0);
        tick();
        chk("arm2_armed", 32'(bus.armed), 32'h1);
        chk("arm2_err", 32'(bus.err), 32'h00);
        chk("arm2_err_any", 32'(bus.err_any), 32'h0);
        bus.mode = 2'b11;
        bus.i = 8'h00;
        tick();
        chk("off_err", 32'(bus.err), 32'h00);
        bus.mode = 2'b01;
        bus.i = 8'h05;
        tick();
        chk("rise_err", 32'(bus.err), 32'h05);
        chk("rise_cnt", 32'(bus.cnt), 32'h1);
        chk("rise_first", 32'(bus.first_ch), 32'h0);
        chk("rise_vld", 32'(bus.first_vld), 32'h1);
        chk("rise_err_any", 32'(bus.err_any), 32'h1);
        bus.mode = 2'b10;
        bus.i = 8'h00;
        tick();
        chk("fall_err", 32'(bus.err), 32'h05);
        chk("fall_cnt", 32'(bus.cnt), 32'h2);
        bus.mode = 2'b11;
        bus.i = 8'hFF;
        tick();
        bus.i = 8'h00;
        tick();
        chk("modeoff_err", 32'(bus.err), 32'h05);
        chk("modeoff_cnt", 32'(bus.cnt), 32'h2);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clr_err", 32'(bus.err), 32'h00);
        chk("clr_cnt", 32'(bus.cnt), 32'h0);
        chk("clr_vld", 32'(bus.first_vld), 32'h0);
        bus.mode = 2'b00;
        bus.e = 8'h0F;
        bus.i = 8'hF0;
        tick();
        chk("mask_err", 32'(bus.err), 32'h00);
        chk("mask_cnt", 32'(bus.cnt), 32'h0);
        bus.e = 8'hFF;
        tick();
        chk("reenable_err", 32'(bus.err), 32'h00);
        bus.i = 8'hF1;
        tick();
        chk("pre_race_err", 32'(bus.err), 32'h01);
        bus.clr = 1'b1;
        bus.i = 8'hF9;
        tick();
        bus.clr = 1'b0;
        chk("race_err", 32'(bus.err), 32'h08);
        chk("race_cnt", 32'(bus.cnt), 32'h1);
        chk("race_first", 32'(bus.first_ch), 32'h3);
        chk("race_vld", 32'(bus.first_vld), 32'h1);
        for (int n = 0; n < 20; n++) begin
            bus.i = bus.i ^ 8'h01;
            tick();
            if (n == 13) chk("sat_reach", 32'(bus.cnt), 32'hF);
        end
        chk("sat_cnt", 32'(bus.cnt), 32'hF);
        chk("sat_first", 32'(bus.first_ch), 32'h3);
        chk("sat_err", 32'(bus.err), 32'h09);
        bus.clr = 1'b1;
        bus.mode = 2'b11;
        tick();
        bus.clr = 1'b0;
        bus.mode = 2'b00;
        for (int n = 0; n < 9; n++) begin
            bus.i = bus.i ^ 8'hFF;
            tick();
        end
        chk("pre_rst_err", 32'(bus.err), 32'hFF);
        chk("pre_rst_cnt", 32'(bus.cnt), 32'h9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_err", 32'(bus.err), 32'h00);
        chk("mid_rst_cnt", 32'(bus.cnt), 32'h0);
        chk("mid_rst_armed", 32'(bus.armed), 32'h0);
        chk("mid_rst_first", 32'(bus.first_ch), 32'h0);
        chk("mid_rst_vld", 32'(bus.first_vld), 32'h0);
        chk("mid_rst_any", 32'(bus.err_any), 32'h0);
        bus.i = bus.i ^ 8'hFF;
        tick();
        chk("rearm1_armed", 32'(bus.armed), 32'h0);
        bus.i = bus.i ^ 8'hFF;
        tick();
        chk("rearm2_armed", 32'(bus.armed), 32'h1);
        chk("rearm2_err", 32'(bus.err), 32'h00);
        bus.i = bus.i ^ 8'hFF;
        tick();
        chk("rearm_det_err", 32'(bus.err), 32'hFF);
        chk("rearm_det_cnt", 32'(bus.cnt), 32'h1);
        chk("rearm_det_first", 32'(bus.first_ch), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
